sram_controller: RTL and testbench

Sequencer between the MIPS MEM stage and the 16-bit external SRAM. It converts each 32-bit load/store from the pipeline into two half-word SRAM accesses with a programmable wait-state count. It drives the SRAM address, write-enable and tri-state data bus, and holds SRAM_NOT_READY high so the pipeline freezes until the word access completes. It sits inside the MEM stage, directly on the pipeline-register outputs (read, write, ALU result, store data).

---
 rtl/mips_pkg.sv | 16 +
 rtl/sram_read_buffer.sv | 36 +++
 rtl/sram_controller.sv | 132 +++++++++++++
 tb/tb_sram_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MEM-stage SRAM definitions: sequencer states, bus widths and word-tag width.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_TAG_W  = 17;
    localparam int SRAM_CNT_W  = 4;

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry read buffer for the SRAM sequencer: word tag, data, valid bit and hit compare.
module sram_read_buffer
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill,
    input  logic [SRAM_TAG_W-1:0] fill_tag,
    input  logic [31:0]           fill_data,
    input  logic                  update,
    input  logic [SRAM_TAG_W-1:0] update_tag,
    input  logic [31:0]           update_data,
    input  logic [SRAM_TAG_W-1:0] lookup_tag,
    output logic                  hit,
    output logic [31:0]           data
);

    logic [SRAM_TAG_W-1:0] tag;
    logic                  valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end else if (update && valid && (tag == update_tag)) begin
            // write-through keeps the cached word coherent with the SRAM
            data <= update_data;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage sequencer: splits each 32-bit load/store into two wait-stated 16-bit SRAM accesses.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            address,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic                   SRAM_NOT_READY,
    output logic [SRAM_ADDR_W-1:0] SRAMaddress,
    output logic                   SRAMWEn,
    inout  wire  [SRAM_DATA_W-1:0] SRAMdata
);

    localparam logic [SRAM_CNT_W-1:0] LAST = SRAM_CNT_W'(WAIT_CYCLES - 1);

    sram_state_t            state, state_next;
    logic [SRAM_CNT_W-1:0]  cnt;
    logic [SRAM_TAG_W-1:0]  addr_q;
    logic [31:0]            wdata_q;
    logic                   is_write;
    logic                   req, in_phase, phase_last, take_hit;
    logic                   bus_oe;
    logic [SRAM_DATA_W-1:0] bus_out;
    logic                   buf_hit;
    logic [31:0]            buf_data;
    logic                   unused_addr_bits;

    assign req              = read | write;
    assign in_phase         = (state == LOW) || (state == HIGH);
    assign phase_last       = (cnt == LAST);
    assign take_hit         = (state == IDLE) && read && !write && buf_hit;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

`ifdef SRAM_READ_BUFFER_EN
    sram_read_buffer u_read_buffer (
        .clk         (clk),
        .rst         (rst),
        .fill        ((state == HIGH) && phase_last && !is_write),
        .fill_tag    (addr_q),
        .fill_data   ({SRAMdata, readdata[15:0]}),
        .update      ((state == HIGH) && phase_last && is_write),
        .update_tag  (addr_q),
        .update_data (wdata_q),
        .lookup_tag  (address[18:2]),
        .hit         (buf_hit),
        .data        (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next     = state;
        SRAM_NOT_READY = 1'b0;
        SRAMWEn        = 1'b1;
        bus_oe         = 1'b0;
        bus_out        = wdata_q[15:0];
        case (state)
            IDLE: begin
                SRAM_NOT_READY = req;
                if (take_hit) state_next = DONE;
                else if (req) state_next = LOW;
            end
            LOW: begin
                SRAM_NOT_READY = 1'b1;
                if (phase_last) state_next = HIGH;
            end
            HIGH: begin
                SRAM_NOT_READY = 1'b1;
                bus_out        = wdata_q[31:16];
                if (phase_last) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        // last phase cycle releases WEn while still driving: data hold
        if (in_phase && is_write) begin
            bus_oe  = 1'b1;
            SRAMWEn = phase_last;
        end
    end

    assign SRAMdata = bus_oe ? bus_out : 'z;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            readdata    <= '0;
            SRAMaddress <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_write    <= 1'b0;
        end else begin
            cnt <= (in_phase && !phase_last) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (take_hit) begin
                        readdata <= buf_data;
                    end else if (req) begin
                        addr_q      <= address[18:2];
                        wdata_q     <= writedata;
                        is_write    <= write;
                        SRAMaddress <= {address[18:2], 1'b0};
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        SRAMaddress <= {addr_q, 1'b1};
                        if (!is_write) readdata[15:0] <= SRAMdata;
                    end
                end
                HIGH: begin
                    if (phase_last && !is_write) readdata[31:16] <= SRAMdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, directed reset/store corner cases, random loads/stores vs a word-level model.
module tb_sram_controller;

    localparam int W    = 5;
    localparam int FULL = 2 * W + 1;
`ifdef SRAM_READ_BUFFER_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif
    localparam int          HIT   = HAS_BUF ? 1 : FULL;
    localparam logic [15:0] PROBE = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst, read, write;
    logic [31:0] address, writedata, readdata;
    logic        SRAM_NOT_READY, SRAMWEn;
    logic [17:0] SRAMaddress;
    wire  [15:0] SRAMdata;

    logic        rd_mode, probe_mode;
    logic [15:0] mem [0:262143];
    logic        tr_we   [0:63];
    logic [17:0] tr_addr [0:63];
    logic [15:0] tr_data [0:63];
    logic [31:0] ref_mem [int];
    int          checks = 0, errors = 0;

    typedef struct {
        logic        r, w;
        logic [31:0] a, wd, exp_rd;
        int          exp_stall;
    } vec_t;
    vec_t tbl [10];

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .read           (read),
        .write          (write),
        .address        (address),
        .writedata      (writedata),
        .readdata       (readdata),
        .SRAM_NOT_READY (SRAM_NOT_READY),
        .SRAMaddress    (SRAMaddress),
        .SRAMWEn        (SRAMWEn),
        .SRAMdata       (SRAMdata)
    );

    always #5 clk = ~clk;

    // SRAM model drives on loads; a probe pattern shows the controller has released the bus
    assign SRAMdata = rd_mode ? mem[SRAMaddress] : (probe_mode ? PROBE : 16'hzzzz);

    always @(negedge clk) if (!SRAMWEn) mem[SRAMaddress] <= SRAMdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request from posedge+1 and holds it until the DONE cycle (stall low).
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output int stall, output logic [31:0] rd);
        bit done;
        done = 1'b0;
        read = r; write = w; address = a; writedata = wd; rd_mode = r & ~w;
        stall = 0; rd = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            tr_we[c] = SRAMWEn; tr_addr[c] = SRAMaddress; tr_data[c] = SRAMdata;
            if (SRAM_NOT_READY) stall++;
            else begin done = 1'b1; rd = readdata; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h still stalled after 64 cycles", a);
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; rd_mode = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        logic        bv;
        logic [16:0] bt;
        logic [31:0] bd, ref_rd;

        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF, 32'h0000_0000, FULL};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,        32'hDEADBEEF, FULL};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0800, 32'h11112222, 32'hDEADBEEF, FULL};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,        32'hDEADBEEF, HIT};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 32'hDEADBEEF, FULL};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,        32'hCAFEF00D, HIT};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0500, 32'h0,        32'h0000_0000, FULL};
        tbl[7] = '{1'b1, 1'b1, 32'h0000_0408, 32'h12345678, 32'h0000_0000, FULL};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,        32'h12345678, FULL};
        tbl[9] = '{1'b1, 1'b0, 32'h8000_0404, 32'h0,        32'hCAFEF00D, FULL};

        // reset held with a pending load
        rst = 1'b0; read = 1'b1; write = 1'b0; address = 32'h404; writedata = '0;
        rd_mode = 1'b0; probe_mode = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_wen", {31'b0, SRAMWEn}, 32'h1);
        check("rst_bus_released", {16'h0, SRAMdata}, {16'h0, PROBE});
        check("rst_sramaddr", {14'h0, SRAMaddress}, 32'h0);
        check("rst_not_ready", {31'b0, SRAM_NOT_READY}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; read = 1'b0;
        @(negedge clk);
        check("idle_not_ready", {31'b0, SRAM_NOT_READY}, 32'h0);
        @(posedge clk); #1;
        probe_mode = 1'b0;

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, st, rd);
            check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
            check($sformatf("vec%0d_readdata", i), rd, tbl[i].exp_rd);
            if (i == 0) begin
                for (int c = 0; c < 12; c++) begin
                    check($sformatf("store_wen_c%0d", c), {31'b0, tr_we[c]},
                          {31'b0, !((c >= 1 && c <= 4) || (c >= 6 && c <= 9))});
                    if (c >= 1 && c <= 10) begin
                        check($sformatf("store_addr_c%0d", c), {14'h0, tr_addr[c]},
                              (c <= 5) ? 32'h202 : 32'h203);
                        check($sformatf("store_data_c%0d", c), {16'h0, tr_data[c]},
                              (c <= 5) ? 32'hBEEF : 32'hDEAD);
                    end
                end
            end
            if (i == 7) check("rw_both_wen_low", {31'b0, tr_we[1]}, 32'h0);
        end

        // reset pulsed at HIGH counter 2 of a store
        rd_mode = 1'b0; write = 1'b1; address = 32'h600; writedata = 32'h55AA33CC;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_high_addr", {14'h0, SRAMaddress}, 32'h301);
        check("mid_high_wen", {31'b0, SRAMWEn}, 32'h0);
        rst = 1'b0; write = 1'b0; probe_mode = 1'b1;
        @(negedge clk);
        check("abort_wen", {31'b0, SRAMWEn}, 32'h1);
        check("abort_bus_released", {16'h0, SRAMdata}, {16'h0, PROBE});
        check("abort_readdata", readdata, 32'h0);
        check("abort_sramaddr", {14'h0, SRAMaddress}, 32'h0);
        check("abort_not_ready", {31'b0, SRAM_NOT_READY}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; probe_mode = 1'b0;
        access(1'b1, 1'b0, 32'h404, 32'h0, st, rd);
        check("post_abort_stall", st, FULL);
        check("post_abort_readdata", rd, 32'hCAFEF00D);

        // random traffic against a word-level model
        bv = 1'b1; bt = 17'h101; bd = 32'hCAFEF00D; ref_rd = 32'hCAFEF00D;
        for (int n = 0; n < 40; n++) begin
            int          idx, op, es;
            logic        r, w;
            logic [31:0] a, wd;
            idx = $urandom_range(0, 7);
            op  = $urandom_range(0, 2);
            w   = (op != 0);
            r   = (op != 1);
            a   = ($urandom & 32'hFFF8_0000) | (idx << 2) | $urandom_range(0, 3);
            wd  = $urandom;
            if (w) begin
                ref_mem[idx] = wd;
                if (HAS_BUF && bv && bt == 17'(idx)) bd = wd;
                es = FULL;
            end else if (HAS_BUF && bv && bt == 17'(idx)) begin
                es = 1;
                ref_rd = bd;
            end else begin
                es = FULL;
                ref_rd = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                bv = 1'b1; bt = 17'(idx); bd = ref_rd;
            end
            access(r, w, a, wd, st, rd);
            check($sformatf("rand%0d_stall", n), st, es);
            check($sformatf("rand%0d_readdata", n), rd, ref_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
